// File: rtl/jtdd_snd_mixer_if.sv
// Audio mixer bus: snapshot inputs, gains, mutes and flags towards the mixer,
// mixed sample plus status back from it.
interface jtdd_snd_mixer_if #(
  parameter int CH   = 4,
  parameter int W    = 16,
  parameter int WOUT = 16
);
  logic                   cen;
  logic [CH*W-1:0]        ch_in;
  logic [CH*8-1:0]        gain;
  logic [CH-1:0]          mute;
  logic                   clr_flags;
  logic signed [WOUT-1:0] mixed;
  logic                   sample;
  logic                   busy;
  logic                   clip;
  logic                   overrun;

  modport master (
    output cen, ch_in, gain, mute, clr_flags,
    input  mixed, sample, busy, clip, overrun
  );

  modport slave (
    input  cen, ch_in, gain, mute, clr_flags,
    output mixed, sample, busy, clip, overrun
  );
endinterface

// File: rtl/jtdd_snd_mixer.sv
// N-channel sound mixer: snapshots the channels on cen, runs one shared
// multiply-accumulate per channel, then saturates the 4.4-scaled sum.
module jtdd_snd_mixer #(
  parameter int CH   = 4,
  parameter int W    = 16,
  parameter int WOUT = 16
) (
  input  logic               clk,
  input  logic               rstn,
  jtdd_snd_mixer_if.slave    bus
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW = W + 9;
  localparam int AW = PW + CW;
  // Wide enough that the shifted accumulator and both rails compare without overflow
  localparam int XW = AW + WOUT;
  localparam logic signed [XW-1:0] SAT_MAX = {{(XW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {{(XW-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                 r_state;
  logic signed [W-1:0]    r_ch_snap   [CH];
  logic [7:0]             r_gain_snap [CH];
  logic [CH-1:0]          r_mute_snap;
  logic [CW-1:0]          r_cnt;
  logic signed [AW-1:0]   r_acc;
  logic signed [WOUT-1:0] r_mixed;
  logic                   r_sample;
  logic                   r_clip;
  logic                   r_overrun;

  logic signed [W-1:0]    w_ch   [CH];
  logic [7:0]             w_gain [CH];
  logic signed [PW-1:0]   w_ch_x;
  logic signed [PW-1:0]   w_gain_x;
  logic signed [PW-1:0]   w_prod;
  logic signed [PW-1:0]   w_term;
  logic signed [AW-1:0]   w_res;
  logic signed [XW-1:0]   w_res_x;
  logic                   w_hi;
  logic                   w_lo;
  logic                   w_clip_set;
  logic                   w_ovr_set;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_unpack
      assign w_ch[gi]   = bus.ch_in[gi*W +: W];
      assign w_gain[gi] = bus.gain[gi*8 +: 8];
    end
  endgenerate

  // Both operands pre-extended to the product width so the multiply stays signed
  assign w_ch_x   = {{9{r_ch_snap[r_cnt][W-1]}}, r_ch_snap[r_cnt]};
  assign w_gain_x = {{(W+1){1'b0}}, r_gain_snap[r_cnt]};
  assign w_prod   = w_ch_x * w_gain_x;
  assign w_term   = r_mute_snap[r_cnt] ? '0 : w_prod;

  assign w_res    = r_acc >>> 4;
  assign w_res_x  = {{WOUT{w_res[AW-1]}}, w_res};
  assign w_hi     = w_res_x > SAT_MAX;
  assign w_lo     = w_res_x < SAT_MIN;

  assign w_clip_set = (r_state == S_OUT) && (w_hi || w_lo);
  assign w_ovr_set  = bus.cen && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_mute_snap <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mixed     <= '0;
      r_sample    <= 1'b0;
      r_clip      <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        r_ch_snap[i]   <= '0;
        r_gain_snap[i] <= '0;
      end
    end else begin
      r_sample  <= 1'b0;
      // A flag being set in the same cycle as a clear keeps the new event
      r_clip    <= (r_clip    & ~bus.clr_flags) | w_clip_set;
      r_overrun <= (r_overrun & ~bus.clr_flags) | w_ovr_set;

      case (r_state)
        S_IDLE: begin
          if (bus.cen) begin
            for (int i = 0; i < CH; i++) begin
              r_ch_snap[i]   <= w_ch[i];
              r_gain_snap[i] <= w_gain[i];
            end
            r_mute_snap <= bus.mute;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_state     <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + {{(AW-PW){w_term[PW-1]}}, w_term};
          if (r_cnt == CW'(CH-1)) begin
            r_state <= S_OUT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_OUT: begin
          if (w_hi) begin
            r_mixed <= SAT_MAX[WOUT-1:0];
          end else if (w_lo) begin
            r_mixed <= SAT_MIN[WOUT-1:0];
          end else begin
            r_mixed <= w_res_x[WOUT-1:0];
          end
          r_sample <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mixed   = r_mixed;
  assign bus.sample  = r_sample;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.clip    = r_clip;
  assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_jtdd_snd_mixer.sv
// Bench for jtdd_snd_mixer (CH=4, W=16, WOUT=16): directed cases plus random
// mixes scored against an integer-arithmetic reference of the mixing rules.
module tb_jtdd_snd_mixer;
  localparam int CH   = 4;
  localparam int W    = 16;
  localparam int WOUT = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_mix    = 0;
  bit   exp_clip = 1'b0;
  bit   exp_ovr  = 1'b0;

  jtdd_snd_mixer_if #(.CH(CH), .W(W), .WOUT(WOUT)) bus ();

  jtdd_snd_mixer #(.CH(CH), .W(W), .WOUT(WOUT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Floor(sum of unmuted ch*gain / 16), clamped to the 16-bit signed range
  function automatic longint ref_mix(input logic [CH*W-1:0] c, input logic [CH*8-1:0] g,
                                     input logic [CH-1:0] m, output bit sat);
    longint sum = 0;
    longint q;
    for (int i = 0; i < CH; i++)
      if (!m[i]) sum += longint'($signed(c[i*W +: W])) * longint'(g[i*8 +: 8]);
    q = sum / 16;
    if (sum < 0 && (sum % 16) != 0) q = q - 1;
    sat = 1'b0;
    if (q > 32767) begin
      q = 32767;
      sat = 1'b1;
    end else if (q < -32768) begin
      q = -32768;
      sat = 1'b1;
    end
    return q;
  endfunction

  // Starts a mix, scrambles inputs during it, optionally re-pulses cen at
  // negedge extra_at (2..5, all inside the busy window), then scores the result.
  task automatic run_mix(input logic [CH*W-1:0] c, input logic [CH*8-1:0] g,
                         input logic [CH-1:0] m, input int extra_at);
    longint exp_val;
    bit     sat;
    int     pulses = 0;
    int     first  = -1;
    longint got_at_pulse = 0;
    exp_val = ref_mix(c, g, m, sat);
    @(negedge clk);
    bus.ch_in = c;
    bus.gain  = g;
    bus.mute  = m;
    bus.cen   = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (bus.sample) begin
        pulses++;
        if (first < 0) begin
          first = i;
          got_at_pulse = longint'(bus.mixed);
        end
      end
      if (i == 1) begin
        check("busy_during_mix", longint'(bus.busy), 1);
        bus.ch_in = {$urandom, $urandom};
        bus.gain  = $urandom;
        bus.mute  = 4'($urandom);
      end
      bus.cen = (i == extra_at);
    end
    if (sat) exp_clip = 1'b1;
    if (extra_at > 0) exp_ovr = 1'b1;
    check("sample_pulses", pulses, 1);
    check("latency", first, CH + 2);
    check("mixed_at_pulse", got_at_pulse, exp_val);
    check("mixed_held", longint'(bus.mixed), exp_val);
    check("clip", longint'(bus.clip), longint'(exp_clip));
    check("overrun", longint'(bus.overrun), longint'(exp_ovr));
    check("busy_after", longint'(bus.busy), 0);
    $display("mix %0d: ch=%h gain=%h mute=%b extra=%0d -> mixed=%0d (exp %0d) clip=%0d ovr=%0d",
             n_mix, c, g, m, extra_at, bus.mixed, exp_val, bus.clip, bus.overrun);
    n_mix++;
  endtask

  task automatic clear_flags();
    @(negedge clk);
    bus.clr_flags = 1'b1;
    @(negedge clk);
    bus.clr_flags = 1'b0;
    exp_clip = 1'b0;
    exp_ovr  = 1'b0;
    check("clr_clip", longint'(bus.clip), 0);
    check("clr_overrun", longint'(bus.overrun), 0);
    $display("clear flags: clip=%0d overrun=%0d", bus.clip, bus.overrun);
  endtask

  function automatic logic [15:0] rand_sample();
    case ($urandom_range(0, 3))
      0: return 16'($signed(32'($urandom_range(0, 4000)) - 32'sd2000));
      1: return 16'h7FFF;
      2: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] rand_gain();
    case ($urandom_range(0, 3))
      0: return 8'h00;
      1: return 8'h10;
      2: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic [CH*W-1:0] c;
    logic [CH*8-1:0] g;
    int pulses;

    bus.cen = 1'b0;
    bus.ch_in = '0;
    bus.gain = '0;
    bus.mute = '0;
    bus.clr_flags = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mixed", longint'(bus.mixed), 0);
    check("rst_sample", longint'(bus.sample), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_clip", longint'(bus.clip), 0);
    check("rst_overrun", longint'(bus.overrun), 0);
    rstn = 1'b1;

    run_mix({16'd0, 16'd0, 16'd0, 16'd1000}, {8'h00, 8'h00, 8'h00, 8'h10}, 4'b0000, 0);
    run_mix({16'd0, 16'd0, -16'sd3, 16'd1000}, {8'h00, 8'h00, 8'h08, 8'h18}, 4'b0000, 0);
    run_mix({4{16'h7000}}, {4{8'h10}}, 4'b0000, 0);

    // Asynchronous reset in the middle of a mix
    @(negedge clk);
    bus.ch_in = {16'd0, 16'd0, 16'd0, 16'd1234};
    bus.gain  = {8'h00, 8'h00, 8'h00, 8'h10};
    bus.mute  = '0;
    bus.cen   = 1'b1;
    @(negedge clk);
    bus.cen = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_mixed", longint'(bus.mixed), 0);
    check("midrst_busy", longint'(bus.busy), 0);
    check("midrst_sample", longint'(bus.sample), 0);
    check("midrst_clip", longint'(bus.clip), 0);
    exp_clip = 1'b0;
    exp_ovr  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.sample) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    $display("reset mid-mix: mixed=%0d pulses=%0d", bus.mixed, pulses);

    run_mix({16'd0, 16'd0, 16'd0, 16'd1000}, {8'h00, 8'h00, 8'h00, 8'h10}, 4'b0000, 0);
    run_mix({16'd0, 16'd0, 16'd0, -16'sd20000}, {8'h00, 8'h00, 8'h00, 8'h20}, 4'b0000, 0);
    clear_flags();
    run_mix({16'd0, 16'd0, 16'd0, 16'd500}, {8'h00, 8'h00, 8'h00, 8'h10}, 4'b0001, 2);
    clear_flags();
    run_mix({16'd7, 16'd9, 16'd11, 16'd13}, {8'hFF, 8'h01, 8'h10, 8'h00}, 4'b0000, 5);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < CH; i++) begin
        c[i*W +: W] = rand_sample();
        g[i*8 +: 8] = rand_gain();
      end
      if ($urandom_range(0, 4) == 0) clear_flags();
      run_mix(c, g, 4'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 5)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
